// File: rtl/spectrogram_frame_receiver.sv
// Receive end of the channel-scan serial link: deserializes sl-framed 16-word
// frames (RTC + 15 channels), presents each word as it completes and keeps a readable bank.
module spectrogram_frame_receiver #(
  parameter int WORD_W    = 12,
  parameter int NUM_WORDS = 16,
  parameter int CH_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sl_in,
  input  logic              sdata_in,
  input  logic              frame_rst_in,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [WORD_W-1:0] rd_data,
  output logic [WORD_W-1:0] word_data,
  output logic [CH_W-1:0]   word_ch,
  output logic              word_valid,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_WORDS);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state, state_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  ch_cnt;       // one bit wider than CH_W so it can hold NUM_WORDS
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] shift_nxt;
  logic [WORD_W-1:0] bank [NUM_WORDS];

  logic start_word;   // sl accepted: this cycle carries the MSB of a new word
  logic shift_bit;    // continuation bit of the word in progress
  logic word_end;     // this cycle carries the LSB
  logic early_sl;     // sl arrived before the word in progress finished
  logic frame_end;    // frame_rst accepted

  assign shift_nxt = {shift_reg[WORD_W-2:0], sdata_in};
  assign rd_data   = bank[rd_ch];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer latches to hold old values.
  always_comb begin
    state_nxt  = state;
    start_word = 1'b0;
    shift_bit  = 1'b0;
    word_end   = 1'b0;
    early_sl   = 1'b0;
    frame_end  = 1'b0;
    if (frame_rst_in) begin
      frame_end = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (sl_in) begin
            start_word = 1'b1;
            state_nxt  = SHIFT;
          end
        end
        SHIFT: begin
          if (sl_in) begin
            // The partial word is dropped; this cycle restarts at the same channel.
            start_word = 1'b1;
            early_sl   = 1'b1;
          end else begin
            shift_bit = 1'b1;
            if (bit_cnt == LAST_BIT) begin
              word_end  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      ch_cnt     <= '0;
      shift_reg  <= '0;
      word_data  <= '0;
      word_ch    <= '0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
      // NOTE: the bank is built from flops with a reset so it reads back as
      // zero after reset; a RAM macro could not be cleared this way.
      for (int i = 0; i < NUM_WORDS; i++) bank[i] <= '0;
    end else begin
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (start_word) begin
        shift_reg <= shift_nxt;
        bit_cnt   <= BIT_W'(1);
      end else if (shift_bit) begin
        shift_reg <= shift_nxt;
        bit_cnt   <= word_end ? '0 : bit_cnt + BIT_W'(1);
      end

      if (early_sl) frame_err <= 1'b1;

      if (word_end) begin
        if (ch_cnt < FULL_CNT) begin
          word_valid                 <= 1'b1;
          word_data                  <= shift_nxt;
          word_ch                    <= ch_cnt[CH_W-1:0];
          bank[ch_cnt[CH_W-1:0]]     <= shift_nxt;
          ch_cnt                     <= ch_cnt + CNT_W'(1);
        end else begin
          // A word beyond NUM_WORDS is received but neither stored nor shown.
          frame_err <= 1'b1;
        end
      end

      if (frame_end) begin
        ch_cnt  <= '0;
        bit_cnt <= '0;
        if (state == IDLE && ch_cnt == FULL_CNT) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spectrogram_frame_receiver.sv
// Self-checking bench for spectrogram_frame_receiver: directed frame scenarios with
// random word contents, compared against a frame-level reference model.
module tb_spectrogram_frame_receiver;

  localparam int WORD_W    = 12;
  localparam int NUM_WORDS = 16;
  localparam int CH_W      = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sl_in = 1'b0;
  logic              sdata_in = 1'b0;
  logic              frame_rst_in = 1'b0;
  logic [CH_W-1:0]   rd_ch = '0;
  logic [WORD_W-1:0] rd_data;
  logic [WORD_W-1:0] word_data;
  logic [CH_W-1:0]   word_ch;
  logic              word_valid;
  logic              frame_done;
  logic              frame_err;
  logic [7:0]        frame_cnt;

  spectrogram_frame_receiver #(
    .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .CH_W(CH_W)
  ) dut (
    .clk(clk), .reset(reset), .sl_in(sl_in), .sdata_in(sdata_in),
    .frame_rst_in(frame_rst_in), .rd_ch(rd_ch), .rd_data(rd_data),
    .word_data(word_data), .word_ch(word_ch), .word_valid(word_valid),
    .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int ch; int data;} word_ev_t;
  typedef struct {int cyc; int kind;} pulse_ev_t;  // kind: 1 done, 2 err, 3 both

  word_ev_t  exp_w[$], obs_w[$];
  pulse_ev_t exp_p[$], obs_p[$];

  int tests = 0;
  int failed = 0;

  // Reference model: channel position, bank contents and clean-frame count.
  int                m_ch = 0;
  logic [WORD_W-1:0] m_bank [NUM_WORDS];
  int                m_frames = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (word_valid) obs_w.push_back('{cyc, int'(word_ch), int'(word_data)});
      if (frame_done || frame_err)
        obs_p.push_back('{cyc, (frame_done ? 1 : 0) + (frame_err ? 2 : 0)});
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sl_in        = 1'b0;
      frame_rst_in = 1'b0;
      sdata_in     = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_bits(input logic [WORD_W-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sl_in    = (i == 0);
      sdata_in = w[WORD_W-1-i];
      tick();
    end
    sl_in = 1'b0;
  endtask

  // One full word; 'restart' marks it as the sl that cuts off a partial word.
  task automatic send_word(input logic [WORD_W-1:0] w, input bit restart);
    int k;
    k = cyc;
    if (restart) exp_p.push_back('{k + 1, 2});
    if (m_ch < NUM_WORDS) begin
      exp_w.push_back('{k + WORD_W, m_ch, int'(w)});
      m_bank[m_ch] = w;
      m_ch++;
    end else begin
      exp_p.push_back('{k + WORD_W, 2});
    end
    send_bits(w, WORD_W);
  endtask

  task automatic send_partial(input int nbits);
    send_bits(WORD_W'($urandom), nbits);
  endtask

  task automatic end_frame(input bit partial);
    int k;
    k = cyc;
    if (!partial && m_ch == NUM_WORDS) begin
      exp_p.push_back('{k + 1, 1});
      m_frames = (m_frames + 1) % 256;
    end else begin
      exp_p.push_back('{k + 1, 2});
    end
    m_ch         = 0;
    frame_rst_in = 1'b1;
    sl_in        = 1'($urandom);  // a coincident sl must be ignored
    sdata_in     = 1'($urandom);
    tick();
    frame_rst_in = 1'b0;
    sl_in        = 1'b0;
  endtask

  task automatic send_words(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i != 0) idle($urandom_range(0, 2));
      send_word(WORD_W'($urandom), 1'b0);
    end
  endtask

  task automatic check_events(input string tag);
    int n;
    idle(2);
    check($sformatf("%s n_words", tag), obs_w.size(), exp_w.size());
    n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s word%0d ch", tag, i), obs_w[i].ch, exp_w[i].ch);
      check($sformatf("%s word%0d data", tag, i), obs_w[i].data, exp_w[i].data);
      check($sformatf("%s word%0d cycle", tag, i), obs_w[i].cyc, exp_w[i].cyc);
    end
    check($sformatf("%s n_pulses", tag), obs_p.size(), exp_p.size());
    n = (obs_p.size() < exp_p.size()) ? obs_p.size() : exp_p.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s pulse%0d kind", tag, i), obs_p[i].kind, exp_p[i].kind);
      check($sformatf("%s pulse%0d cycle", tag, i), obs_p[i].cyc, exp_p[i].cyc);
    end
    obs_w.delete(); exp_w.delete(); obs_p.delete(); exp_p.delete();
    check($sformatf("%s frame_cnt", tag), int'(frame_cnt), m_frames);
    for (int i = 0; i < NUM_WORDS; i++) begin
      rd_ch    = CH_W'(i);
      sdata_in = 1'($urandom);
      tick();
      check($sformatf("%s bank[%0d]", tag, i), int'(rd_data), int'(m_bank[i]));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " word_valid"}, int'(word_valid), 0);
    check({tag, " frame_done"}, int'(frame_done), 0);
    check({tag, " frame_err"},  int'(frame_err),  0);
    check({tag, " frame_cnt"},  int'(frame_cnt),  0);
    check({tag, " word_data"},  int'(word_data),  0);
    check({tag, " word_ch"},    int'(word_ch),    0);
    check({tag, " rd_data"},    int'(rd_data),    0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_WORDS; i++) m_bank[i] = '0;

    // Reset state
    #1;
    check_cleared("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);

    // Clean frame with a known ramp of words
    for (int i = 0; i < NUM_WORDS; i++) send_word(WORD_W'(i * 12'h111), 1'b0);
    end_frame(1'b0);
    check_events("clean");
    rd_ch = CH_W'(5);
    #1;
    check("clean rd_ch5", int'(rd_data), 12'h555);

    // Two back-to-back random frames, frame_rst alone in the 1-cycle gap
    tick();
    send_words(NUM_WORDS, 1'b0);
    end_frame(1'b0);
    send_words(NUM_WORDS, 1'b0);
    end_frame(1'b0);
    check_events("b2b");

    // Early sl at bit 7 of CH3, restarted with 0xA5C
    send_words(3, 1'b1);
    send_partial(7);
    send_word(12'hA5C, 1'b1);
    send_words(NUM_WORDS - 4, 1'b1);
    end_frame(1'b0);
    check_events("early");

    // Short frame, then a full frame starting again at channel 0
    send_words(10, 1'b1);
    end_frame(1'b0);
    send_words(NUM_WORDS, 1'b1);
    end_frame(1'b0);
    check_events("short");

    // frame_rst at bit 6 of word 4, then a clean frame
    send_words(4, 1'b0);
    send_partial(6);
    end_frame(1'b1);
    check_events("midrst");
    send_words(NUM_WORDS, 1'b1);
    end_frame(1'b0);
    check_events("after_midrst");

    // Overflow: a 17th word is dropped with frame_err, the frame still ends clean
    send_words(NUM_WORDS + 1, 1'b0);
    end_frame(1'b0);
    check_events("overflow");

    // Async reset at bit 5 of word 9
    send_words(9, 1'b0);
    send_partial(5);
    #2;
    reset = 1'b1;
    rd_ch = CH_W'(4);
    #1;
    check_cleared("async_reset");
    for (int i = 0; i < NUM_WORDS; i++) m_bank[i] = '0;
    m_ch     = 0;
    m_frames = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_events("post_reset");
    send_words(NUM_WORDS, 1'b1);
    end_frame(1'b0);
    check_events("reset_frame");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spectrogram_frame_receiver.md
Name: spectrogram_frame_receiver

Overview:
- Receive end of the channel-scan serial link: deserializes the bitstream framed by the scan sequencer's shift/load strobe (sl) and end-of-frame pulse (rst).
- Each frame is 16 words (word 0 = RTC, words 1..15 = CH1..CH15) of WORD_W bits, MSB first, one bit per clk.
- Outputs each word with its channel index as it completes, stores words in a readable 16-entry bank, and flags frame completion or framing errors.

Parameters:
- WORD_W, 12, bits per word; also cycles per channel slot.
- NUM_WORDS, 16, words per frame (RTC + 15 channels).
- CH_W, 4, channel index width; must satisfy 2^CH_W >= NUM_WORDS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sl_in  in  1  word-start strobe; high during the MSB bit cycle
- sdata_in  in  1  serial data; sampled every clk
- frame_rst_in  in  1  end-of-frame pulse (1 cycle after last word)
- rd_ch  in  CH_W  bank read address
- rd_data  out  WORD_W  bank[rd_ch]; combinational read
- word_data  out  WORD_W  last completed word; registered
- word_ch  out  CH_W  channel index of word_data
- word_valid  out  1  1-cycle pulse per completed word
- frame_done  out  1  1-cycle pulse: frame of exactly NUM_WORDS words ended cleanly
- frame_err  out  1  1-cycle pulse: framing violation detected
- frame_cnt  out  8  count of clean frames; wraps 255->0

Behaviour:
- Reset (async, active-high): state IDLE, bit_cnt=0, ch_cnt=0, shift reg=0, all bank entries=0, word_data=0, word_ch=0, word_valid=0, frame_done=0, frame_err=0, frame_cnt=0. Reset mid-word discards the partial word; no pulse is emitted.
- State machine: IDLE, SHIFT.
- IDLE:
  - sl_in=1 -> shift reg <= {.., sdata_in}, bit_cnt <= 1, go SHIFT.
  - sl_in=0 -> stay IDLE.
- SHIFT:
  - Each cycle, shift in sdata_in (MSB first) and increment bit_cnt.
  - When the WORD_W-th bit is sampled, go IDLE. Next cycle: word_valid=1, word_data = assembled word, word_ch = ch_cnt[CH_W-1:0], bank[ch_cnt] written, ch_cnt incremented.
- Latency: sl_in high at cycle t -> word_valid at t+WORD_W (t+12 by default).
- Back-to-back words: the sl_in of the next word arrives in the cycle after the last bit. It is accepted in IDLE in that same cycle with no gap, so continuous 12-cycle slots are received loss-free.
- Early sl_in in SHIFT (bit_cnt<WORD_W): the partial word is discarded and frame_err pulses next cycle. The sl_in cycle restarts a new word (bit_cnt=1) at the same ch_cnt.
- frame_rst_in=1 (highest priority; a coincident sl_in is ignored). ch_cnt <= 0, go IDLE, then:
  - State IDLE and ch_cnt==NUM_WORDS -> frame_done pulse next cycle, frame_cnt++.
  - Otherwise (short frame, or partial word in progress) -> frame_err pulse next cycle; the partial word is discarded.
- Overflow: an sl_in while ch_cnt==NUM_WORDS means a 17th word. The word is received but neither stored nor output, and frame_err pulses when it completes. ch_cnt saturates at NUM_WORDS and is 5 bits wide.
- frame_done and frame_err are never high in the same cycle.
- rd_data reflects a bank write in the cycle after the word_valid cycle's clock edge, i.e. it is registered-write, async-read.
- sdata_in outside a word (IDLE, sl_in=0) is ignored.

Test Plan:
- Clean frame: 16 slots, each sl+12 bits, words 0x000,0x111,...,0xFFF, then frame_rst pulse -> 16 word_valid pulses at t+12 with word_ch 0..15 and matching data; frame_done 1 cycle after frame_rst; frame_cnt=1; rd_ch=5 -> rd_data=0x555.
- Back-to-back frames: two clean frames, 1-cycle idle gap containing frame_rst -> 32 word_valid, 2 frame_done, frame_cnt=2, no frame_err.
- Early sl: sl at bit 7 of CH3, then full word 0xA5C -> frame_err once; word_ch=3 with data 0xA5C; remaining channels are not shifted.
- Short frame: 10 words then frame_rst -> frame_err pulse, no frame_done, frame_cnt unchanged, next frame starts at word_ch=0.
- frame_rst mid-word at bit 6 of word 4 -> no word_valid for word 4; frame_err; ch_cnt=0; bank[4] unchanged.
- Async reset asserted at bit 5 of word 9 -> all outputs 0 immediately; bank cleared; next clean frame yields frame_done and frame_cnt=1.
